// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - sequential shift-add unsigned multiplier, STEP multiplier bits per cycle
// Optional early termination on exhausted multiplier bits: define SEQ_MUL_EARLY_EXIT_EN.
module seq_mul #(
    parameter int N    = 16,
    parameter int STEP = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] c,
    output logic           busy
);

    localparam int NDIG = N / STEP;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    // Elaboration guard: the digit loop only covers b exactly when STEP divides N.
    generate
        if (N < 2 || STEP < 1 || (N % STEP) != 0) begin : g_bad_params
            $error("seq_mul: N must be >= 2 and STEP must divide N");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [N-1:0]      a_r;
    logic [N-1:0]      b_r;
    logic [2*N-1:0]    acc;
    logic [CW-1:0]     cnt;
    logic [N+STEP-1:0] pp;
    logic [2*N-1:0]    pp_sh;
    logic              last_digit;
    logic              b_zero;

    // Partial product of the current (lowest remaining) digit, aligned to its weight.
    always_comb begin
        pp    = {{STEP{1'b0}}, a_r} * {{N{1'b0}}, b_r[STEP-1:0]};
        pp_sh = (2*N)'(pp) << (32'(cnt) * STEP);
    end

`ifdef SEQ_MUL_EARLY_EXIT_EN
    logic rest_zero;

    // Finish as soon as no nonzero digit remains above the current one.
    always_comb begin
        rest_zero  = ((b_r >> STEP) == '0);
        last_digit = rest_zero;
        b_zero     = (b == '0);
    end
`else
    // Fixed latency: finish on the last digit regardless of operand values.
    always_comb begin
        last_digit = (cnt == CW'(NDIG - 1));
        b_zero     = 1'b0;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        busy      = (state == BUSY);
        out_valid = (state == DONE);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = b_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last_digit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, accumulate one digit per BUSY edge, load c at the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
            cnt <= '0;
            c   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r <= a;
                        b_r <= b;
                        acc <= '0;
                        cnt <= '0;
                        if (b_zero) begin
                            c <= '0;
                        end
                    end
                end
                BUSY: begin
                    acc <= acc + pp_sh;
                    cnt <= cnt + 1'b1;
                    b_r <= b_r >> STEP;
                    if (last_digit) begin
                        c <= acc + pp_sh;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
